// File: rtl/struct_alu_pkg.sv
// ---------------------------------------------------------------------------
// struct_alu_pkg
//   Shared definitions for the struct_alu_pipe block: the operation code
//   enumeration and its width, plus a small helper for op classification.
//   No ports (package).
// ---------------------------------------------------------------------------
package struct_alu_pkg;

    localparam int OP_W = 2;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 2'd0,
        ALU_SUB = 2'd1,
        ALU_XOR = 2'd2,
        ALU_ACC = 2'd3
    } alu_op_e;

    // True for the only op that reads and writes the running accumulator.
    function automatic logic is_acc_op(input alu_op_e op);
        return (op == ALU_ACC);
    endfunction

endpackage : struct_alu_pkg

// File: rtl/struct_alu_core.sv
// ---------------------------------------------------------------------------
// struct_alu_core
//   Purely combinational datapath sitting between pipeline stages S1 and S2.
//   Produces the per-transaction result, the operand equality flag and the
//   value the accumulator should take if this transaction advances.
//
//   Ports
//     ops      in   2*WIDTH  packed operand bundle {data_A, data_B}
//     op       in   OP_W     operation code (alu_op_e encoding)
//     acc      in   ACC_W    current accumulator register
//     enable   in   1        0 forces res to 0 and leaves acc untouched
//     acc_clr  in   1        accumulator clear, applied before any add
//     res      out  ACC_W    result for this transaction
//     eq       out  1        data_A == data_B
//     acc_next out  ACC_W    accumulator value to load when this advances
// ---------------------------------------------------------------------------
module struct_alu_core
    import struct_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 24
) (
    input  logic [2*WIDTH-1:0] ops,
    input  logic [OP_W-1:0]    op,
    input  logic [ACC_W-1:0]   acc,
    input  logic               enable,
    input  logic               acc_clr,
    output logic [ACC_W-1:0]   res,
    output logic               eq,
    output logic [ACC_W-1:0]   acc_next
);

    typedef struct packed {
        logic [WIDTH-1:0] data_A;
        logic [WIDTH-1:0] data_B;
    } operand_t;

    operand_t         ops_s;
    alu_op_e          op_e;
    logic [WIDTH:0]   sum_w;
    logic [WIDTH:0]   diff_w;
    logic [ACC_W-1:0] acc_base;
    logic [ACC_W-1:0] acc_sum;

    assign ops_s = ops;
    assign op_e  = alu_op_e'(op);

    // One extra bit keeps the carry of ADD and the borrow of SUB.
    assign sum_w  = {1'b0, ops_s.data_A} + {1'b0, ops_s.data_B};
    assign diff_w = {1'b0, ops_s.data_A} - {1'b0, ops_s.data_B};

    // Clear happens before the add so a coincident clear + ACC yields A+B.
    assign acc_base = acc_clr ? '0 : acc;
    assign acc_sum  = acc_base + ACC_W'(sum_w);

    assign eq = (ops_s.data_A == ops_s.data_B);

    always_comb begin
        res = '0;
        if (enable) begin
            unique case (op_e)
                ALU_ADD: res = ACC_W'(sum_w);
                ALU_SUB: res = ACC_W'(diff_w);
                ALU_XOR: res = ACC_W'(ops_s.data_A ^ ops_s.data_B);
                ALU_ACC: res = acc_sum;
                default: res = '0;
            endcase
        end
    end

    // Non-ACC or disabled transactions still honour a pending clear.
    assign acc_next = (enable && is_acc_op(op_e)) ? acc_sum : acc_base;

endmodule : struct_alu_core

// File: rtl/struct_alu_pipe.sv
// ---------------------------------------------------------------------------
// struct_alu_pipe
//   Two-stage pipelined operand-pair ALU with valid/ready handshakes on both
//   sides and a persistent running accumulator.
//     S1: registers the {A,B} operand struct and the op code.
//     S2: registers the computed result, equality flag and echoed op.
//   The accumulator is written only on the cycle an S1 transaction moves
//   into S2, so its change lines up with the ACC result appearing at out_*.
//
//   Ports
//     clk        in   1      clock, rising edge
//     rst        in   1      asynchronous active-high reset
//     enable     in   1      0: results forced to 0, accumulator frozen
//     acc_clr    in   1      synchronous accumulator clear
//     in_valid   in   1      upstream transaction valid
//     in_ready   out  1      transaction can be accepted this cycle
//     in_a       in   WIDTH  operand A
//     in_b       in   WIDTH  operand B
//     in_op      in   2      ADD=0, SUB=1, XOR=2, ACC=3
//     out_valid  out  1      result valid
//     out_ready  in   1      downstream accepts result
//     out_res    out  ACC_W  result
//     out_eq     out  1      A == B for this transaction
//     out_op     out  2      op code echoed with the result
//     acc_value  out  ACC_W  accumulator register
// ---------------------------------------------------------------------------
module struct_alu_pipe
    import struct_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int ACC_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             acc_clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_res,
    output logic             out_eq,
    output logic [1:0]       out_op,
    output logic [ACC_W-1:0] acc_value
);

    if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
        $error("struct_alu_pipe: ACC_W must be at least WIDTH+1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] data_A;
        logic [WIDTH-1:0] data_B;
    } operand_t;

    // Stage 1
    logic     s1_valid_q, s1_valid_d;
    operand_t s1_ops_q,   s1_ops_d;
    alu_op_e  s1_op_q,    s1_op_d;

    // Stage 2
    logic             s2_valid_q, s2_valid_d;
    logic [ACC_W-1:0] s2_res_q,   s2_res_d;
    logic             s2_eq_q,    s2_eq_d;
    alu_op_e          s2_op_q,    s2_op_d;

    // Accumulator
    logic [ACC_W-1:0] acc_q, acc_d;

    // Handshake
    logic s2_ready;
    logic s1_ready;
    logic s1_load;
    logic s1_adv;

    // Core outputs
    logic [ACC_W-1:0] core_res;
    logic             core_eq;
    logic [ACC_W-1:0] core_acc_next;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign s1_load  = in_valid && s1_ready;
    assign s1_adv   = s1_valid_q && s2_ready;

    struct_alu_core #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_core (
        .ops      (s1_ops_q),
        .op       (s1_op_q),
        .acc      (acc_q),
        .enable   (enable),
        .acc_clr  (acc_clr),
        .res      (core_res),
        .eq       (core_eq),
        .acc_next (core_acc_next)
    );

    always_comb begin
        s1_valid_d = s1_ready ? in_valid : s1_valid_q;
        s1_ops_d   = s1_ops_q;
        s1_op_d    = s1_op_q;
        if (s1_load) begin
            s1_ops_d.data_A = in_a;
            s1_ops_d.data_B = in_b;
            s1_op_d         = alu_op_e'(in_op);
        end
    end

    // S2 payload only moves on an advance, so a stalled result stays put.
    always_comb begin
        s2_valid_d = s2_ready ? s1_valid_q : s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_eq_d    = s2_eq_q;
        s2_op_d    = s2_op_q;
        if (s1_adv) begin
            s2_res_d = core_res;
            s2_eq_d  = core_eq;
            s2_op_d  = s1_op_q;
        end
    end

    // The core already folds acc_clr into acc_next for an advancing
    // transaction; otherwise a clear on its own just zeroes the register.
    always_comb begin
        acc_d = acc_q;
        if (s1_adv) begin
            acc_d = core_acc_next;
        end else if (acc_clr) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_ops_q   <= '0;
            s1_op_q    <= ALU_ADD;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_eq_q    <= 1'b0;
            s2_op_q    <= ALU_ADD;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_ops_q   <= s1_ops_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_eq_q    <= s2_eq_d;
            s2_op_q    <= s2_op_d;
            acc_q      <= acc_d;
        end
    end

    assign in_ready  = s1_ready;
    assign out_valid = s2_valid_q;
    assign out_res   = s2_res_q;
    assign out_eq    = s2_eq_q;
    assign out_op    = s2_op_q;
    assign acc_value = acc_q;

endmodule : struct_alu_pipe

// File: tb/tb_struct_alu_pipe.sv
module tb_struct_alu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        acc_clr;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] out_res;
    logic        out_eq;
    logic [1:0]  out_op;
    logic [23:0] acc_value;

    struct_alu_pipe #(.WIDTH(16), .ACC_W(24)) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .acc_clr   (acc_clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_res   (out_res),
        .out_eq    (out_eq),
        .out_op    (out_op),
        .acc_value (acc_value)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] res;
        logic        eq;
        logic [1:0]  op;
        logic [23:0] acc;
    } exp_t;

    int          total = 0;
    int          bad   = 0;
    exp_t        exp_q[$];
    int unsigned acc_m = 0;
    logic        clr_at_adv = 1'b0;
    bit          rand_bp = 1'b0;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_XOR = 2'd2;
    localparam logic [1:0] OP_ACC = 2'd3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Reference: plain arithmetic on the op definitions, applied in
    // acceptance order with the enable / clear in force for that transaction.
    task automatic model_push(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        exp_t        e;
        int unsigned r;
        int unsigned ua = a;
        int unsigned ub = b;
        if (clr_at_adv) acc_m = 0;
        case (op)
            OP_ADD:  r = ua + ub;
            OP_SUB:  r = (ua + 32'h20000 - ub) % 32'h20000;
            OP_XOR:  r = ua ^ ub;
            default: begin
                if (enable) acc_m = (acc_m + ua + ub) % 32'h1000000;
                r = acc_m;
            end
        endcase
        if (!enable) r = 0;
        e.res = r[23:0];
        e.eq  = (ua == ub);
        e.op  = op;
        e.acc = acc_m[23:0];
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_res", out_res, e.res);
                check("out_eq", out_eq, e.eq);
                check("out_op", out_op, e.op);
                check("acc_with_result", acc_value, e.acc);
            end
        end
    end

    // Entered and left at posedge+1; returns right after the accepting edge.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        bit done = 1'b0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                model_push(a, b, op);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("drain_empty", exp_q.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic latency_send(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        send(a, b, op);
        in_valid = 1'b0;
        @(negedge clk);
        check("latency_cycle1_not_valid", out_valid, 32'd0);
        @(negedge clk);
        check("latency_cycle2_valid", out_valid, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_clr();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        acc_m   = 0;
        check("acc_clr_standalone", acc_value, 32'd0);
    endtask

    initial begin : stim
        logic [15:0] ra, rb;
        logic [1:0]  rop;
        logic [23:0] held;

        rst = 1'b1; enable = 1'b1; acc_clr = 1'b0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_out_res", out_res, 32'd0);
        check("rst_out_eq", out_eq, 32'd0);
        check("rst_out_op", out_op, 32'd0);
        check("rst_acc_value", acc_value, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // ADD with carry out, latency check
        latency_send(16'hFFFF, 16'h0001, OP_ADD);
        drain();

        // SUB borrow and equal operands, XOR, back to back
        send(16'h0005, 16'h0007, OP_SUB);
        send(16'h1234, 16'h1234, OP_SUB);
        send(16'hA5A5, 16'h0FF0, OP_XOR);
        drain();

        // Accumulate
        send(16'hFFFF, 16'hFFFF, OP_ACC);
        send(16'hFFFF, 16'hFFFF, OP_ACC);
        send(16'hFFFF, 16'hFFFF, OP_ACC);
        drain();
        check("acc_after_three", acc_value, 32'h05FFFA);
        pulse_clr();

        // Preload to 0xFFFFF0 then wrap to zero
        for (int i = 0; i < 128; i++) send(16'hFFFF, 16'hFFFF, OP_ACC);
        send(16'h00F0, 16'h0000, OP_ACC);
        drain();
        check("acc_preload", acc_value, 32'hFFFFF0);
        send(16'h0010, 16'h0000, OP_ACC);
        drain();
        check("acc_wrap", acc_value, 32'd0);

        // Backpressure: two accepts fill the pipe, output holds, then release
        out_ready = 1'b0;
        send(16'h0001, 16'h0002, OP_ADD);
        send(16'h0010, 16'h0020, OP_ADD);
        in_a = 16'h0100; in_b = 16'h0200; in_op = OP_ADD; in_valid = 1'b1;
        @(negedge clk);
        held = out_res;
        check("bp_held_first", held, 32'h3);
        for (int i = 0; i < 3; i++) begin
            check("bp_in_ready_low", in_ready, 32'd0);
            check("bp_out_valid", out_valid, 32'd1);
            check("bp_out_res_hold", out_res, held);
            @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(16'h0100, 16'h0200, OP_ADD);
        send(16'h1000, 16'h2000, OP_ADD);
        drain();

        // enable=0 freezes the accumulator and zeroes the result
        send(16'h0005, 16'h0006, OP_ACC);
        drain();
        enable = 1'b0;
        send(16'h0003, 16'h0004, OP_ACC);
        drain();
        enable = 1'b1;
        check("acc_frozen_when_disabled", acc_value, 32'd11);

        // Clear coincident with an advancing ACC
        clr_at_adv = 1'b1;
        send(16'h0002, 16'h0002, OP_ACC);
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        @(posedge clk); #1;
        acc_clr    = 1'b0;
        clr_at_adv = 1'b0;
        drain();
        check("acc_clr_with_acc", acc_value, 32'd4);

        // Clear coincident with a disabled ACC
        enable     = 1'b0;
        clr_at_adv = 1'b1;
        send(16'h0005, 16'h0005, OP_ACC);
        in_valid = 1'b0;
        acc_clr  = 1'b1;
        @(posedge clk); #1;
        acc_clr    = 1'b0;
        clr_at_adv = 1'b0;
        drain();
        enable = 1'b1;
        check("acc_clr_disabled_acc", acc_value, 32'd0);

        // Randomized batches with random backpressure; enable held per batch
        for (int batch = 0; batch < 4; batch++) begin
            enable  = (batch != 2);
            rand_bp = 1'b1;
            for (int n = 0; n < 40; n++) begin
                ra  = 16'($urandom);
                rb  = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
                rop = 2'($urandom_range(0, 3));
                send(ra, rb, rop);
                if ($urandom_range(0, 3) == 0) idle(1);
            end
            rand_bp = 1'b0;
            drain();
        end
        enable = 1'b1;

        // Asynchronous reset with both stages full
        out_ready = 1'b0;
        send(16'h0100, 16'h0000, OP_ACC);
        send(16'h0001, 16'h0002, OP_ADD);
        in_valid = 1'b0;
        check("pre_reset_out_valid", out_valid, 32'd1);
        check("pre_reset_acc", acc_value, acc_m);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_out_valid", out_valid, 32'd0);
        check("async_rst_acc", acc_value, 32'd0);
        check("async_rst_in_ready", in_ready, 32'd1);
        check("async_rst_out_res", out_res, 32'd0);
        exp_q.delete();
        acc_m = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        latency_send(16'h1234, 16'h0001, OP_ADD);
        drain();
        check("post_reset_out_valid", out_valid, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_struct_alu_pipe

// File: doc/struct_alu_pipe.md
Name: struct_alu_pipe

Overview:
- Parametrised, two-stage pipelined operand-pair ALU.
- Operands A/B travel as a packed struct bundle. Each transaction produces an ADD, SUB, XOR or accumulate result plus an equality flag.
- Sits between an upstream operand producer and a downstream consumer, with valid/ready handshakes on both sides.
- Provides a running accumulator that persists across transactions.

Parameters:
- WIDTH, 16: operand width in bits.
- ACC_W, 24: result and accumulator width; must be >= WIDTH+1 (elaboration-time assertion).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- enable  in  1  when 0, results forced to 0 and accumulator not updated.
- acc_clr  in  1  synchronous accumulator clear.
- in_valid  in  1  upstream transaction valid.
- in_ready  out  1  block can accept a transaction this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_op  in  2  op code: ADD=0, SUB=1, XOR=2, ACC=3.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_res  out  ACC_W  result.
- out_eq  out  1  in_a == in_b for this transaction.
- out_op  out  2  op code echoed with the result.
- acc_value  out  ACC_W  current accumulator contents.

Behaviour:
- Reset (async, rst=1): both stage valids 0, accumulator 0. Outputs during and after reset: out_valid=0, out_res=0, out_eq=0, out_op=0, acc_value=0, in_ready=1. Reset mid-transaction discards all in-flight data; no partial result is emitted.
- Pipeline: S1 registers {a,b} struct and op. S2 computes and registers the result.
- Accept: a transaction is accepted when in_valid && in_ready. out_valid rises 2 cycles after acceptance, assuming no stall.
- Stall rules (per-stage ready):
  - s2_ready = !s2_valid || out_ready
  - s1_ready = !s1_valid || s2_ready
  - in_ready = s1_ready
- Full throughput: with out_ready held at 1, one result per cycle.
- Output holding: while out_valid && !out_ready, out_res, out_eq and out_op hold stable.
- Arithmetic, computed when S1 advances into S2:
  - ADD: zero-extend(A+B computed in WIDTH+1 bits).
  - SUB: A-B computed in WIDTH+1 bits, bit WIDTH = borrow, then zero-extended.
  - XOR: zero-extend(A^B).
  - ACC: acc_next = acc + zero-extend(A+B), modulo 2^ACC_W (wraps, no saturation); result = acc_next.
- out_eq = (A==B), independent of op and of enable.
- enable is sampled when S1 advances into S2. If 0: out_res=0 for that transaction and the accumulator is unchanged, even for ACC. out_eq and out_op are still valid.
- acc_clr:
  - With no ACC transaction advancing that cycle: acc <= 0.
  - Coinciding with an ACC transaction advancing (enable=1): clear-then-add, acc <= zero-extend(A+B), and the result equals that value.
  - Coinciding with an ACC transaction advancing while enable=0: acc <= 0 and out_res=0 for that transaction.
  - acc_clr does not affect pipeline valids.
- Accumulator timing: updates only when an ACC transaction advances into S2, never while S2 is stalled. acc_value reflects the register, and its change appears the same cycle that out_valid presents that ACC result.

Decomposition:
- Package struct_alu_pkg:
  - op enum alu_op_e (ALU_ADD, ALU_SUB, ALU_XOR, ALU_ACC), 2 bits.
  - localparam OP_W=2.
- Operand struct: typedef struct packed {logic [WIDTH-1:0] data_A; logic [WIDTH-1:0] data_B;}, declared inside the module because it depends on WIDTH.
- Sub-module struct_alu_core: purely combinational. Inputs: operand struct, op, acc, enable, acc_clr. Outputs: res, eq, acc_next. Instantiated once, between S1 and S2.

Test Plan (WIDTH=16, ACC_W=24):
- Reset then ADD: A=0xFFFF, B=0x0001 -> out_res=0x010000, out_eq=0; out_valid 2 cycles after accept.
- SUB: A=0x0005, B=0x0007 -> out_res=0x01FFFE (borrow set). SUB A=B=0x1234 -> out_res=0, out_eq=1.
- ACC sequence:
  - Three ACC ops of A=0xFFFF, B=0xFFFF from acc=0 -> results 0x01FFFE, 0x03FFFC, 0x05FFFA.
  - Preload acc to 0xFFFFF0, then ACC A=0x10, B=0 -> result and acc 0x000000 (wrap).
- Backpressure: stream 4 ADD ops with out_ready=0 -> in_ready drops after 2 accepts and out_res holds. Raising out_ready -> all 4 emerge in order, none lost or duplicated.
- enable=0, ACC A=3, B=4 -> out_res=0, acc unchanged, out_eq=0. acc_clr coincident with ACC A=2, B=2 (enable=1) -> acc=4, out_res=4.
- Assert rst mid-stream with both stages full -> out_valid=0 and acc_value=0 immediately (asynchronous). After release, first accepted op emerges 2 cycles later with correct value.
